fetch_sequencer: RTL
====================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, byte address of first fetch after reset or restart.
REQ-002 Parameter IMEM_WORDS, default 100, number of 32-bit words in the instruction memory.
REQ-003 Parameter HALT_WORD, default 32'hFFFFFFFF, instruction encoding that stops fetching.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  begin fetching from IDLE, or restart from HALT.
REQ-007 stall  input  1  hold current pc; suppress instr_valid.
REQ-008 redirect_valid  input  1  load pc from redirect_addr (branch/jump).
REQ-009 redirect_addr  input  32  byte target address.
REQ-010 instruction  input  32  combinational read data of instruction memory at pc.
REQ-011 pc  output  32  byte address driven to instruction memory.
REQ-012 instr_out  output  32  registered fetched instruction.
REQ-013 instr_valid  output  1  instr_out holds a new instruction this cycle.
REQ-014 halted  output  1  sequencer is in HALT.
REQ-015 fault  output  1  HALT entered due to misaligned or out-of-range pc.
REQ-016 fetch_count  output  16  number of valid fetches since last start (see Configuration).

Function
REQ-017 FSM states IDLE, RUN, STALL, HALT; halted SHALL equal (state==HALT).
REQ-018 IDLE: start=1 -> RUN next cycle; pc held at RESET_PC; instr_valid=0.
REQ-019 RUN, no redirect, no stall: instr_out<=instruction, instr_valid<=1, pc<=pc+4; one-cycle latency from pc to instr_out.
REQ-020 RUN with stall=1 and no redirect -> STALL; pc and instr_out held; instr_valid<=0.
REQ-021 STALL: stall=0 -> RUN next cycle with no fetch that cycle; pc unchanged; instr_valid=0.
REQ-022 redirect_valid in RUN or STALL has priority over stall: pc<=redirect_addr, instr_valid<=0 (in-flight fetch squashed), state<=RUN.
REQ-023 redirect_valid in IDLE or HALT SHALL be ignored.
REQ-024 redirect_addr[1:0]!=0 or redirect_addr>=IMEM_WORDS*4 -> HALT with fault<=1; pc unchanged.
REQ-025 Fetched instruction==HALT_WORD -> word captured with instr_valid=1, then HALT next cycle; pc not advanced.
REQ-026 Normal fetch of word IMEM_WORDS-1 -> word captured with instr_valid=1, then HALT with fault=0; no wrap-around to 0.
REQ-027 HALT: pc, instr_out frozen; instr_valid=0; start=1 -> pc<=RESET_PC, fault<=0, fetch_count<=0, state RUN.
REQ-028 start while in RUN or STALL SHALL be ignored.
REQ-029 pc SHALL always be word-aligned and < IMEM_WORDS*4 when driven to memory.

Reset
REQ-030 rst_n=0 SHALL immediately force state=IDLE, pc=RESET_PC, instr_out=0, instr_valid=0, halted=0, fault=0, fetch_count=0, regardless of clk.
REQ-031 Reset asserted mid-RUN or mid-STALL SHALL discard any in-flight fetch or pending redirect; first fetch after release requires start.

Configuration
REQ-032 Macro FETCH_PERF_CNT_EN defined: fetch_count increments by 1 on every cycle with instr_valid=1, saturates at 16'hFFFF, clears on start.
REQ-033 Macro FETCH_PERF_CNT_EN undefined: fetch_count tied to 16'h0000; no counter flops; all other behaviour identical.

Verification
REQ-034 Reset, start, memory words 0..3 = 00000000, 01098020, 3510003D, 8E680028 -> instr_out shows them on 4 consecutive cycles, pc 0,4,8,C,10.
REQ-035 stall high 3 cycles after pc=8 -> pc stays 8, instr_valid=0 for 4 cycles (3 stall + 1 resume), then 3510003D fetched.
REQ-036 redirect_valid with addr 0x70 while stall=1 -> next pc=0x70, instr_valid=0, following cycle instr_out=014C9820.
REQ-037 redirect_addr=0x72, then separately 0x190 (IMEM_WORDS=100) -> HALT, fault=1, pc unchanged; start -> pc=0, fault=0.
REQ-038 HALT_WORD at word 6 -> word 6 delivered valid, halted=1 next cycle, pc=0x18 frozen; rst_n low mid-RUN -> all outputs reset values same cycle.
REQ-039 With FETCH_PERF_CNT_EN, REQ-034 run of 4 fetches -> fetch_count=4; without macro -> fetch_count=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Instruction fetch sequencer. Drives a byte address to a combinational
//   instruction memory, registers the returned word, and walks the address
//   forward by one word per cycle. Supports stall, redirect (branch/jump),
//   halting on a HALT_WORD encoding, halting at the last memory word, and
//   halting with a fault on a misaligned or out-of-range redirect.
//
// Ports
//   clk             : clock, all state updates on the rising edge
//   rst_n           : asynchronous active-low reset
//   start           : leave IDLE, or restart from HALT (ignored in RUN/STALL)
//   stall           : hold pc, suppress instr_valid
//   redirect_valid  : load pc from redirect_addr (RUN/STALL only)
//   redirect_addr   : byte target address
//   instruction     : combinational memory read data at pc
//   pc              : byte address to instruction memory
//   instr_out       : registered fetched instruction
//   instr_valid     : instr_out holds a new instruction this cycle
//   halted          : sequencer is in HALT
//   fault           : HALT was entered because of a bad redirect target
//   fetch_count     : valid fetches since last start (optional counter)
//   dbg_state_o     : current FSM state encoding, for observation
//
// Configuration
//   FETCH_PERF_CNT_EN : when defined, fetch_count is a saturating counter;
//                       otherwise it is tied to zero and no flops exist.
//
// Output handshake: instr_valid is a single-cycle qualifier with no ready
// back-pressure. The consumer must take instr_out in the cycle instr_valid
// is high; stall is the only way to pause the instruction stream.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 100,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  input  logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic        halted,
  output logic        fault,
  output logic [15:0] fetch_count,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  localparam logic [31:0] MEM_BYTES = 32'(IMEM_WORDS * 4);
  localparam logic [31:0] LAST_PC   = 32'((IMEM_WORDS - 1) * 4);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic        redirect_bad;
  logic        start_accept;

  // Targets must be word aligned and inside memory; anything else faults.
  assign redirect_bad = (redirect_addr[1:0] != 2'b00) || (redirect_addr >= MEM_BYTES);
  assign start_accept = start && ((state_q == S_IDLE) || (state_q == S_HALT));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = 1'b0;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: begin
        if (start_accept) begin
          state_d = S_RUN;
          pc_d    = RESET_PC;
        end
      end
      S_RUN, S_STALL: begin
        if (redirect_valid) begin
          // Redirect beats stall; the fetch in this cycle is squashed.
          if (redirect_bad) begin
            state_d = S_HALT;
            fault_d = 1'b1;
          end else begin
            state_d = S_RUN;
            pc_d    = redirect_addr;
          end
        end else if (stall) begin
          state_d = S_STALL;
        end else if (state_q == S_STALL) begin
          // First cycle after a stall releases is a bubble, no fetch.
          state_d = S_RUN;
        end else begin
          instr_d = instruction;
          valid_d = 1'b1;
          // The halting word (or the last memory word) is still delivered;
          // pc stays on it rather than wrapping or running past memory.
          if ((instruction == HALT_WORD) || (pc_q == LAST_PC)) begin
            state_d = S_HALT;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
      end
      S_HALT: begin
        if (start_accept) begin
          state_d = S_RUN;
          pc_d    = RESET_PC;
          fault_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Counts alongside valid_d so the count matches instr_valid in the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (start_accept) begin
      cnt_d = '0;
    end else if (valid_d && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fetch_count = cnt_q;
`else
  assign fetch_count = 16'h0000;
`endif

  assign pc          = pc_q;
  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign halted      = (state_q == S_HALT);
  assign fault       = fault_q;
  assign dbg_state_o = state_q;

endmodule
